mpdiv8_phase_decoder: RTL and testbench

- Receive end of the 8-phase interleaved divider bus. Samples the 8 phases in the CLK domain, decodes the circular 4-of-8 pattern back into a 3-bit phase index, and checks that the index advances by exactly one per CLK.
- Provides lock status, error pulses and an error counter to FOD bring-up and monitoring logic. Detects stuck, skipped or glitched divider phases.

---
 rtl/mpdiv8_phase_decoder.sv | 150 +++++++++++++++
 tb/tb_mpdiv8_phase_decoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpdiv8_phase_decoder.sv
// Receive-side decoder for the 8-phase interleaved divider bus.
// Recovers the phase index, tracks sequential lock and counts phase errors.
module mpdiv8_phase_decoder #(
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             CLK,
  input  logic             NARST,
  input  logic [7:0]       FMP,
  input  logic             CLR_ERR,
  output logic [2:0]       PH_IDX,
  output logic             PH_VLD,
  output logic             LOCK,
  output logic             WRAP,
  output logic             ERR_PULSE,
  output logic [ERR_W-1:0] ERR_CNT
);

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  localparam logic [7:0]       LOCK_CNT_C = 8'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX_C  = {ERR_W{1'b1}};

  // A legal word is four contiguous ones on the ring; the single 1->0
  // boundary (bit i high, bit i+1 low) marks the phase index.
  function automatic logic [3:0] decode_fn(input logic [7:0] f);
    logic [7:0] fall;
    logic [2:0] idx;
    logic       legal;
    fall = f & ~{f[0], f[7:1]};
    idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = fall[i] ? i[2:0] : idx;
    end
    legal = ($countones(f) == 32'd4) && ($countones(fall) == 32'd1);
    return {legal, idx};
  endfunction

  logic [7:0] fmp_q_r;
  logic       legal_s;
  logic [2:0] idx_s;
  logic       step_ok_s;
  logic       err_s;
  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] acq_cnt_r;
  logic [7:0] acq_cnt_nxt_s;
  logic [7:0] acq_inc_s;

  assign {legal_s, idx_s} = decode_fn(fmp_q_r);
  assign step_ok_s = legal_s & PH_VLD & (idx_s == (PH_IDX + 3'd1));
  assign acq_inc_s = acq_cnt_r + 8'd1;

  // Sampling stage and decoded-index output stage
  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      fmp_q_r <= 8'h00;
      PH_VLD  <= 1'b0;
      PH_IDX  <= 3'd0;
      WRAP    <= 1'b0;
    end else begin
      fmp_q_r <= FMP;
      PH_VLD  <= legal_s;
      PH_IDX  <= legal_s ? idx_s : PH_IDX;
      WRAP    <= step_ok_s & (idx_s == 3'd0);
    end
  end

  // Lock FSM next-state and acquisition counter
  always_comb begin
    state_nxt_s   = state_r;
    acq_cnt_nxt_s = acq_cnt_r;
    err_s         = 1'b0;
    case (state_r)
      ST_UNLOCK: begin
        if (legal_s) begin
          state_nxt_s   = ST_ACQ;
          acq_cnt_nxt_s = 8'd1;
        end else begin
          state_nxt_s   = ST_UNLOCK;
          acq_cnt_nxt_s = 8'd0;
        end
      end
      ST_ACQ: begin
        if (step_ok_s) begin
          acq_cnt_nxt_s = acq_inc_s;
          if (acq_inc_s == LOCK_CNT_C) begin
            state_nxt_s = ST_LOCK;
          end else begin
            state_nxt_s = ST_ACQ;
          end
        end else if (legal_s) begin
          state_nxt_s   = ST_ACQ;
          acq_cnt_nxt_s = 8'd1;
        end else begin
          state_nxt_s   = ST_UNLOCK;
          acq_cnt_nxt_s = 8'd0;
        end
      end
      ST_LOCK: begin
        if (!step_ok_s) begin
          err_s         = 1'b1;
          state_nxt_s   = ST_UNLOCK;
          acq_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s   = ST_LOCK;
        end
      end
      default: begin
        state_nxt_s   = ST_UNLOCK;
        acq_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // FSM state register; LOCK follows the transition on the same edge
  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      state_r   <= ST_UNLOCK;
      acq_cnt_r <= 8'd0;
      LOCK      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      acq_cnt_r <= acq_cnt_nxt_s;
      LOCK      <= (state_nxt_s == ST_LOCK);
    end
  end

  // Error reporting; a coincident clear wins over the increment
  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      ERR_PULSE <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      ERR_PULSE <= err_s;
      if (CLR_ERR) begin
        ERR_CNT <= '0;
      end else if (err_s && (ERR_CNT != ERR_MAX_C)) begin
        ERR_CNT <= ERR_CNT + {{(ERR_W-1){1'b0}}, 1'b1};
      end else begin
        ERR_CNT <= ERR_CNT;
      end
    end
  end

endmodule

// File: tb/tb_mpdiv8_phase_decoder.sv
// Randomized self-checking bench: two decoder instances (ERR_W 8 and 2) share
// one stimulus stream and are compared every cycle against a run-length model.
module tb_mpdiv8_phase_decoder;

  localparam int LOCK_CNT = 16;

  logic       CLK = 1'b0;
  logic       NARST;
  logic [7:0] FMP;
  logic       CLR_ERR;

  logic [2:0] a_ph_idx, b_ph_idx;
  logic       a_ph_vld, b_ph_vld, a_lock, b_lock, a_wrap, b_wrap, a_err_pulse, b_err_pulse;
  logic [7:0] a_err_cnt;
  logic [1:0] b_err_cnt;
  logic [23:0] obs_s;

  mpdiv8_phase_decoder #(.LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut_a (
    .CLK(CLK), .NARST(NARST), .FMP(FMP), .CLR_ERR(CLR_ERR),
    .PH_IDX(a_ph_idx), .PH_VLD(a_ph_vld), .LOCK(a_lock), .WRAP(a_wrap),
    .ERR_PULSE(a_err_pulse), .ERR_CNT(a_err_cnt)
  );

  mpdiv8_phase_decoder #(.LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut_b (
    .CLK(CLK), .NARST(NARST), .FMP(FMP), .CLR_ERR(CLR_ERR),
    .PH_IDX(b_ph_idx), .PH_VLD(b_ph_vld), .LOCK(b_lock), .WRAP(b_wrap),
    .ERR_PULSE(b_err_pulse), .ERR_CNT(b_err_cnt)
  );

  assign obs_s = {a_ph_idx, a_ph_vld, a_lock, a_wrap, a_err_pulse, a_err_cnt,
                  b_ph_idx, b_ph_vld, b_lock, b_wrap, b_err_pulse, b_err_cnt};

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  int cur    = 0;

  // reference model state
  logic [7:0] m_fmpq;
  logic       m_vld, m_lock, m_wrap, m_errp;
  logic [2:0] m_idx;
  int         m_run;
  logic [7:0] m_cnt_a;
  logic [1:0] m_cnt_b;

  function automatic logic [7:0] pat(input int i);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 4; k++) p[((i - k) % 8 + 8) % 8] = 1'b1;
    return p;
  endfunction

  function automatic int m_decode(input logic [7:0] f);
    for (int i = 0; i < 8; i++) if (f == pat(i)) return i;
    return -1;
  endfunction

  function automatic logic [23:0] exp_vec();
    return {m_idx, m_vld, m_lock, m_wrap, m_errp, m_cnt_a,
            m_idx, m_vld, m_lock, m_wrap, m_errp, m_cnt_b};
  endfunction

  task automatic model_reset();
    m_fmpq = 8'h00; m_vld = 1'b0; m_lock = 1'b0; m_wrap = 1'b0; m_errp = 1'b0;
    m_idx = 3'd0; m_run = 0; m_cnt_a = 8'd0; m_cnt_b = 2'd0;
  endtask

  // One edge of the model: stage-2 decisions use the word captured one edge ago.
  task automatic model_step(input logic [7:0] f, input logic clr);
    int   ix;
    logic lg, step, err;
    ix   = m_decode(m_fmpq);
    lg   = (ix >= 0);
    step = lg && m_vld && (ix == (int'(m_idx) + 1) % 8);
    err  = 1'b0;
    if (m_lock) begin
      if (!step) begin err = 1'b1; m_lock = 1'b0; m_run = 0; end
    end else begin
      if (!lg) m_run = 0;
      else if (step && m_run > 0) m_run++;
      else m_run = 1;
      if (m_run == LOCK_CNT) m_lock = 1'b1;
    end
    m_wrap = step && (ix == 0);
    m_errp = err;
    if (clr) begin
      m_cnt_a = 8'd0; m_cnt_b = 2'd0;
    end else if (err) begin
      if (m_cnt_a != 8'hFF) m_cnt_a++;
      if (m_cnt_b != 2'b11) m_cnt_b++;
    end
    m_vld = lg;
    if (lg) m_idx = ix[2:0];
    m_fmpq = f;
  endtask

  task automatic drive(input logic [7:0] f, input logic c);
    FMP = f; CLR_ERR = c;
    @(posedge CLK);
    model_step(f, c);
    #1;
  endtask

  task automatic bad_sample(output logic [7:0] f);
    if ($urandom_range(0, 1) == 1) begin
      cur = (cur + int'($urandom_range(2, 8))) % 8;
      f = pat(cur);
    end else begin
      do f = 8'($urandom); while (m_decode(f) >= 0);
    end
  endtask

  task automatic test_reset();
    NARST = 1'b0; FMP = 8'h00; CLR_ERR = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      n_chk++;
      if (obs_s !== 24'h0) begin n_fail++; $display("FAIL reset got=%h want=%h", obs_s, 24'h0); end
    end
    NARST = 1'b1;
  endtask

  task automatic test_ideal();
    for (int k = 1; k <= 40; k++) begin
      cur = (k - 1) % 8;
      drive(pat(cur), 1'b0);
      n_chk++;
      if (obs_s !== exp_vec()) begin n_fail++; $display("FAIL ideal k=%0d got=%h want=%h", k, obs_s, exp_vec()); end
      if (k == 2) begin
        n_chk++;
        if (a_ph_vld !== 1'b1 || a_ph_idx !== 3'd0) begin n_fail++; $display("FAIL ideal_first vld=%b idx=%0d want 1/0", a_ph_vld, a_ph_idx); end
      end
      if (k == 16 || k == 17) begin
        n_chk++;
        if (a_lock !== (k == 17)) begin n_fail++; $display("FAIL ideal_lock_edge k=%0d lock=%b want %b", k, a_lock, k == 17); end
      end
      if (k == 9 || k == 10) begin
        n_chk++;
        if (a_wrap !== (k == 10)) begin n_fail++; $display("FAIL ideal_wrap k=%0d wrap=%b want %b", k, a_wrap, k == 10); end
      end
    end
    n_chk++;
    if (a_err_cnt !== 8'd0) begin n_fail++; $display("FAIL ideal_errcnt got=%0d want 0", a_err_cnt); end
  endtask

  task automatic test_skip();
    int laps;
    laps = int'($urandom_range(0, 2)) * 8;
    for (int k = 0; k < laps || cur != 4; k++) begin
      cur = (cur + 1) % 8;
      drive(pat(cur), 1'b0);
      n_chk++;
      if (obs_s !== exp_vec()) begin n_fail++; $display("FAIL skip_pre got=%h want=%h", obs_s, exp_vec()); end
    end
    cur = 6;
    drive(pat(cur), 1'b0);
    for (int e = 0; e <= 16; e++) begin
      cur = (cur + 1) % 8;
      drive(pat(cur), 1'b0);
      n_chk++;
      if (obs_s !== exp_vec()) begin n_fail++; $display("FAIL skip e=%0d got=%h want=%h", e, obs_s, exp_vec()); end
      if (e == 0) begin
        n_chk++;
        if (a_err_pulse !== 1'b1 || a_err_cnt !== 8'd1 || a_lock !== 1'b0) begin
          n_fail++; $display("FAIL skip_err pulse=%b cnt=%0d lock=%b want 1/1/0", a_err_pulse, a_err_cnt, a_lock);
        end
      end
      if (e == 15 || e == 16) begin
        n_chk++;
        if (a_lock !== (e == 16)) begin n_fail++; $display("FAIL skip_relock e=%0d lock=%b want %b", e, a_lock, e == 16); end
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] bads [3];
    logic [7:0] rb;
    logic [2:0] held;
    bads[0] = 8'h00; bads[1] = 8'hFF; bads[2] = 8'h55;
    for (int j = 0; j < 3; j++) begin
      n_chk++;
      if (a_lock !== 1'b1) begin n_fail++; $display("FAIL illegal_prelock j=%0d lock=%b want 1", j, a_lock); end
      held = cur[2:0];
      drive(bads[j], 1'b0);
      for (int k = 0; k < 18; k++) begin
        cur = (cur + 1) % 8;
        drive(pat(cur), 1'b0);
        n_chk++;
        if (obs_s !== exp_vec()) begin n_fail++; $display("FAIL illegal j=%0d k=%0d got=%h want=%h", j, k, obs_s, exp_vec()); end
        if (k == 0) begin
          n_chk++;
          if (a_ph_vld !== 1'b0 || a_ph_idx !== held || a_err_pulse !== 1'b1) begin
            n_fail++; $display("FAIL illegal_sample j=%0d vld=%b idx=%0d pulse=%b want 0/%0d/1", j, a_ph_vld, a_ph_idx, a_err_pulse, held);
          end
        end
      end
      n_chk++;
      if (a_err_cnt !== 8'(j + 2)) begin n_fail++; $display("FAIL illegal_cnt j=%0d got=%0d want %0d", j, a_err_cnt, j + 2); end
    end
    // drop lock, then hit an illegal word while still acquiring
    drive(8'h00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cur = (cur + 1) % 8;
      drive(pat(cur), 1'b0);
    end
    do rb = 8'($urandom); while (m_decode(rb) >= 0);
    drive(rb, 1'b0);
    cur = (cur + 1) % 8;
    drive(pat(cur), 1'b0);
    n_chk++;
    if (obs_s !== exp_vec()) begin n_fail++; $display("FAIL acq_illegal got=%h want=%h", obs_s, exp_vec()); end
    n_chk++;
    if (a_err_pulse !== 1'b0 || a_err_cnt !== 8'd5 || a_lock !== 1'b0 || a_ph_vld !== 1'b0) begin
      n_fail++; $display("FAIL acq_illegal_nocount pulse=%b cnt=%0d lock=%b vld=%b want 0/5/0/0", a_err_pulse, a_err_cnt, a_lock, a_ph_vld);
    end
  endtask

  task automatic test_stuck();
    for (int k = 0; k < 20; k++) begin
      drive(8'h0F, k == 4);
      n_chk++;
      if (obs_s !== exp_vec()) begin n_fail++; $display("FAIL stuck k=%0d got=%h want=%h", k, obs_s, exp_vec()); end
    end
    cur = 3;
    n_chk++;
    if (a_ph_idx !== 3'd3 || a_ph_vld !== 1'b1 || a_lock !== 1'b0 || a_err_cnt !== 8'd0 || a_err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL stuck_final idx=%0d vld=%b lock=%b cnt=%0d pulse=%b want 3/1/0/0/0", a_ph_idx, a_ph_vld, a_lock, a_err_cnt, a_err_pulse);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] f;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 18; k++) begin
        cur = (cur + 1) % 8;
        drive(pat(cur), 1'b0);
        n_chk++;
        if (obs_s !== exp_vec()) begin n_fail++; $display("FAIL sat e=%0d k=%0d got=%h want=%h", e, k, obs_s, exp_vec()); end
        if (e == 5 && k == 0) begin
          n_chk++;
          if (b_err_cnt !== 2'd3 || a_err_cnt !== 8'd5) begin n_fail++; $display("FAIL sat_stick b=%0d a=%0d want 3/5", b_err_cnt, a_err_cnt); end
        end
      end
      n_chk++;
      if (a_lock !== 1'b1) begin n_fail++; $display("FAIL sat_relock e=%0d lock=%b want 1", e, a_lock); end
      bad_sample(f);
      drive(f, 1'b0);
    end
    cur = (cur + 1) % 8;
    drive(pat(cur), 1'b1);
    n_chk++;
    if (b_err_pulse !== 1'b1 || b_err_cnt !== 2'd0 || a_err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL sat_clear pulse=%b b=%0d a=%0d want 1/0/0", b_err_pulse, b_err_cnt, a_err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int r;
    for (int k = 0; k < 18; k++) begin
      cur = (cur + 1) % 8;
      drive(pat(cur), 1'b0);
      n_chk++;
      if (obs_s !== exp_vec()) begin n_fail++; $display("FAIL rmid_pre k=%0d got=%h want=%h", k, obs_s, exp_vec()); end
    end
    n_chk++;
    if (a_lock !== 1'b1) begin n_fail++; $display("FAIL rmid_prelock lock=%b want 1", a_lock); end
    #3;
    NARST = 1'b0;
    #1;
    n_chk++;
    if (obs_s !== 24'h0) begin n_fail++; $display("FAIL rmid_async got=%h want=%h", obs_s, 24'h0); end
    model_reset();
    FMP = 8'h00; CLR_ERR = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    NARST = 1'b1;
    r = int'($urandom_range(0, 7));
    for (int k = 1; k <= 17; k++) begin
      cur = (r + k - 1) % 8;
      drive(pat(cur), 1'b0);
      n_chk++;
      if (obs_s !== exp_vec()) begin n_fail++; $display("FAIL rmid k=%0d got=%h want=%h", k, obs_s, exp_vec()); end
      if (k == 16 || k == 17) begin
        n_chk++;
        if (a_lock !== (k == 17)) begin n_fail++; $display("FAIL rmid_relock k=%0d lock=%b want %b", k, a_lock, k == 17); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ideal();
    test_skip();
    test_illegal();
    test_stuck();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
